// File: rtl/serial_add_ctrl_if.sv
// Start/done handshake and operand/result bus of the bit-serial adder controller.
// Optional SERIAL_SUB_EN adds the 'sub' request qualifier.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef SERIAL_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell sequenced LSB first over WIDTH cycles.
// Define SERIAL_SUB_EN to add subtraction (a - b) selected by bus.sub.
module full_adder_cell (
  input  logic ai,
  input  logic bi,
  input  logic ci,
  output logic si,
  output logic co,
  output logic Gi,
  output logic Pi
);
  assign Gi = ai & bi;
  assign Pi = ai ^ bi;
  assign si = Pi ^ ci;
  assign co = Gi | (Pi & ci);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             ovf_pend;
  logic             si;
  logic             co;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  full_adder_cell u_cell (
    .ai (a_sr[0]),
    .bi (b_sr[0]),
    .ci (carry),
    .si (si),
    .co (co),
    .Gi (),
    .Pi ()
  );

`ifdef SERIAL_SUB_EN
  // Two's-complement subtract: invert B and force the initial carry.
  always_comb begin
    b_load = bus.sub ? ~bus.b : bus.b;
    c_load = bus.sub ? 1'b1 : bus.cin;
  end
`else
  always_comb begin
    b_load = bus.b;
    c_load = bus.cin;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      sum_sr   <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      ovf_pend <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_sr     <= bus.a;
            b_sr     <= b_load;
            carry    <= c_load;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          carry  <= co;
          sum_sr <= {si, sum_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          // MSB cycle: carry into vs out of the top bit gives signed overflow.
          if (cnt == LAST) begin
            ovf_pend <= carry ^ co;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          bus.sum  <= sum_sr;
          bus.cout <= carry;
          bus.ovf  <= ovf_pend;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller. One instance of the team's 1-bit full-adder cell (ports ai, bi, ci, si, co, Gi, Pi) is sequenced over WIDTH clock cycles, LSB first, to add two WIDTH-bit operands. The block holds the carry flip-flop, the operand and sum shift registers, and a start/done handshake. It is the area-minimal alternative to the ripple/lookahead adder in the register-file datapath.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured when start is accepted
b  input  WIDTH  operand B; captured when start is accepted
cin  input  1  carry-in; captured when start is accepted
busy  output  1  high while state is RUN or DONE
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  result; held until the next accepted start
cout  output  1  final carry-out; held with sum
ovf  output  1  signed overflow (carry into MSB xor cout); held with sum

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, bit counter=0, carry FF=0, operand shift registers=0. Reset mid-operation aborts immediately. No partial result is kept.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE: when start=1 at edge T:
  - load a and b into shift registers
  - carry FF <= cin
  - cnt <= 0
  - state <= RUN
  - sum/cout/ovf keep their old values until DONE.
- RUN, one bit per cycle:
  - cell inputs: ai = A_sr[0], bi = B_sr[0], ci = carry FF.
  - at each edge: carry FF <= co; sum_sr <= {si, sum_sr[WIDTH-1:1]}; A_sr and B_sr shift right by 1; cnt <= cnt+1.
  - when cnt == WIDTH-1, also capture ovf_pending = ci xor co (carry-in vs carry-out of the MSB), then state <= DONE.
- DONE (exactly 1 cycle):
  - sum = sum_sr, cout = carry FF, ovf = ovf_pending; all registered and stable from this cycle on.
  - done=1.
  - next state is IDLE.
- Latency: start accepted at edge T, done=1 in the cycle after edge T+WIDTH+1. Example: WIDTH=8 gives done 9 cycles after acceptance.
- Throughput: one operation per WIDTH+2 cycles. A start asserted in the DONE cycle is ignored. A start held high is re-accepted on the first IDLE cycle.
- start while busy=1: ignored. Operands are not re-sampled and the in-flight result is not disturbed.
- a, b and cin may change freely after acceptance.
- done never asserts without a preceding accepted start since reset.
- cnt width is $clog2(WIDTH). cnt never wraps in RUN because the transition happens at WIDTH-1.
- Gi and Pi from the cell are unused (left open). No combinational path from inputs to outputs.

Optional Feature:
Macro SERIAL_SUB_EN.
- Defined: adds input port sub (1 bit), sampled together with start.
  - sub=1: B is loaded as ~b, carry FF is loaded with 1, and cin is ignored. The result is a-b.
  - cout=1 means no borrow (a>=b unsigned). ovf is signed overflow of a-b.
  - sub=0: behaviour is identical to the macro-absent case.
- Undefined: no sub port; add only; logic identical to the base description.

Test Plan:
1. WIDTH=8, a=8'h35, b=8'h4A, cin=0, start pulse -> busy=1 next cycle; done=1 exactly 9 cycles after acceptance; sum=8'h7F, cout=0, ovf=0.
2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. Then a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1.
3. a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1. Then a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
4. start held high throughout, operands changed to 8'h11/8'h22 during RUN:
   - first result is from the original operands, done high for 1 cycle only;
   - start ignored in the DONE cycle;
   - second operation accepted the following IDLE cycle and returns 8'h33.
5. rst asserted at RUN cnt=4 -> same cycle (async): busy=0, done=0, sum=0, cout=0, ovf=0. After release, a new start with 8'h01+8'h02 gives sum=8'h03.
6. SERIAL_SUB_EN defined:
   - sub=1, a=8'h10, b=8'h20 -> sum=8'hF0, cout=0, ovf=0.
   - sub=1, a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
